// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the core pipeline stage registers.
//  - Per-field info structs (register write, LSU, CSR, exception) that travel
//    with an instruction down the pipe.
//  - Stage payload structs if_id_t, id_ex_t, ex_mem_t, mem_wb_t. A stage wrapper
//    passes $bits(<stage>_t) as WIDTH and the matching *_INVALID constant as
//    RESET_PAYLOAD to pipe_skid_stage.
//  - valid_count(): number of held entries from the two slot valid bits.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Architectural NOP (andi r0, r0, 0); flushed or reset slots carry it so a
    // stray consumer of an invalid payload sees a harmless instruction.
    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    typedef struct packed {
        logic       we;
        logic [4:0] rd;
    } rw_info_t;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [2:0] size;
    } lsu_info_t;

    // is_ertn rides in the payload so the flush it causes lines up with the
    // instruction that requested it.
    typedef struct packed {
        logic        is_csr;
        logic        is_ertn;
        logic [13:0] addr;
    } csr_info_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] ecode;
    } except_info_t;

    typedef struct packed {
        logic [31:0]  inst;
        logic [31:0]  pc;
        rw_info_t     rw;
        lsu_info_t    lsu;
        csr_info_t    csr;
        except_info_t excp;
    } if_id_t;

    typedef struct packed {
        logic [31:0]  inst;
        logic [31:0]  pc;
        logic [31:0]  src1;
        logic [31:0]  src2;
        rw_info_t     rw;
        lsu_info_t    lsu;
        csr_info_t    csr;
        except_info_t excp;
    } id_ex_t;

    typedef struct packed {
        logic [31:0]  inst;
        logic [31:0]  pc;
        logic [31:0]  result;
        rw_info_t     rw;
        lsu_info_t    lsu;
        csr_info_t    csr;
        except_info_t excp;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0]  inst;
        logic [31:0]  pc;
        logic [31:0]  wdata;
        rw_info_t     rw;
        lsu_info_t    lsu;
        csr_info_t    csr;
        except_info_t excp;
    } mem_wb_t;

    // Invalid-payload constants used as RESET_PAYLOAD for each stage.
    localparam if_id_t  IF_ID_INVALID  = '{INST_NOP, 32'h0, '0, '0, '0, '0};
    localparam id_ex_t  ID_EX_INVALID  = '{INST_NOP, 32'h0, 32'h0, 32'h0, '0, '0, '0, '0};
    localparam ex_mem_t EX_MEM_INVALID = '{INST_NOP, 32'h0, 32'h0, '0, '0, '0, '0};
    localparam mem_wb_t MEM_WB_INVALID = '{INST_NOP, 32'h0, 32'h0, '0, '0, '0, '0};

    // Held-entry count from the main and skid valid bits.
    function automatic logic [1:0] valid_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage slot of a pipeline stage: a valid bit plus a WIDTH-bit payload.
//  clk    in   clock
//  rst    in   synchronous active-high reset (valid=0, payload=RESET_PAYLOAD)
//  clr    in   flush; same effect as rst
//  load   in   capture din and set valid
//  drop   in   clear valid, payload is kept (nothing new was written)
//  din    in   payload to capture
//  valid  out  slot holds an entry
//  dout   out  held payload
// Priority: rst/clr > load > drop > hold.
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int unsigned      WIDTH         = 128,
    parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // Slot state: the payload only moves on a load or a reset/flush.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_r <= 1'b0;
            data_r  <= RESET_PAYLOAD;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else if (drop) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

    assign valid = valid_r;
    assign dout  = data_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Generic valid/ready pipeline stage register with flush, stall and an optional
// skid slot. With SKID=1 in_ready comes straight from the skid valid flop, so
// the downstream ready chain is cut at this stage.
//  clk        in   clock
//  rst        in   synchronous active-high reset
//  flush      in   drop all held entries; a coinciding push is discarded
//  stall      in   hold the output side (out_valid forced low, no pop)
//  in_valid   in   upstream has an entry
//  in_ready   out  stage accepts an entry this cycle
//  in_data    in   upstream payload
//  out_valid  out  entry presented downstream
//  out_ready  in   downstream accepts
//  out_data   out  payload of the oldest held entry (driven even when stalled)
//  occupancy  out  held entries, 0..1+SKID (registered)
// -----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH         = 128,
    parameter int unsigned      SKID          = 1,
    parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             push_s;
    logic             pop_s;
    logic             in_ready_s;
    logic             main_valid_s;
    logic [WIDTH-1:0] main_data_s;
    logic             main_valid_nx_s;
    logic             skid_valid_nx_s;
    logic [1:0]       occ_r;

    // out_valid is not gated by flush: a pop in the flush cycle still completes.
    assign out_valid = main_valid_s & ~stall;
    assign out_data  = main_data_s;
    assign in_ready  = in_ready_s;
    assign push_s    = in_valid & in_ready_s;
    assign pop_s     = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic             skid_valid_s;
            logic [WIDTH-1:0] skid_data_s;
            logic             main_load_s;
            logic             main_drop_s;
            logic [WIDTH-1:0] main_din_s;
            logic             skid_load_s;
            logic             skid_drop_s;

            // A push is only possible while the skid slot is empty.
            assign in_ready_s = ~skid_valid_s;

            // Main/skid next-state: main always holds the oldest entry.
            always_comb begin
                main_load_s     = 1'b0;
                main_drop_s     = 1'b0;
                main_din_s      = in_data;
                skid_load_s     = 1'b0;
                skid_drop_s     = 1'b0;
                main_valid_nx_s = main_valid_s;
                skid_valid_nx_s = skid_valid_s;
                if (!main_valid_s) begin
                    if (push_s) begin
                        main_load_s     = 1'b1;
                        main_valid_nx_s = 1'b1;
                    end else begin
                        main_valid_nx_s = 1'b0;
                    end
                end else if (pop_s && skid_valid_s) begin
                    // Shift skid into main; in_ready was low, so no push now.
                    main_load_s     = 1'b1;
                    main_din_s      = skid_data_s;
                    skid_drop_s     = 1'b1;
                    skid_valid_nx_s = 1'b0;
                end else if (pop_s) begin
                    if (push_s) begin
                        main_load_s = 1'b1;
                    end else begin
                        main_drop_s     = 1'b1;
                        main_valid_nx_s = 1'b0;
                    end
                end else if (push_s) begin
                    skid_load_s     = 1'b1;
                    skid_valid_nx_s = 1'b1;
                end else begin
                    main_valid_nx_s = main_valid_s;
                end
            end

            pipe_slot #(.WIDTH(WIDTH), .RESET_PAYLOAD(RESET_PAYLOAD)) u_main (
                .clk   (clk),
                .rst   (rst),
                .clr   (flush),
                .load  (main_load_s),
                .drop  (main_drop_s),
                .din   (main_din_s),
                .valid (main_valid_s),
                .dout  (main_data_s)
            );

            pipe_slot #(.WIDTH(WIDTH), .RESET_PAYLOAD(RESET_PAYLOAD)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .clr   (flush),
                .load  (skid_load_s),
                .drop  (skid_drop_s),
                .din   (in_data),
                .valid (skid_valid_s),
                .dout  (skid_data_s)
            );
        end else begin : g_single
            logic main_load_s;
            logic main_drop_s;

            // Single slot: accept when empty or when the held entry leaves now.
            assign in_ready_s = ~main_valid_s | (out_ready & ~stall);

            // Single-slot next-state: push replaces, bare pop empties.
            always_comb begin
                main_load_s     = 1'b0;
                main_drop_s     = 1'b0;
                main_valid_nx_s = main_valid_s;
                skid_valid_nx_s = 1'b0;
                if (push_s) begin
                    main_load_s     = 1'b1;
                    main_valid_nx_s = 1'b1;
                end else if (pop_s) begin
                    main_drop_s     = 1'b1;
                    main_valid_nx_s = 1'b0;
                end else begin
                    main_valid_nx_s = main_valid_s;
                end
            end

            pipe_slot #(.WIDTH(WIDTH), .RESET_PAYLOAD(RESET_PAYLOAD)) u_main (
                .clk   (clk),
                .rst   (rst),
                .clr   (flush),
                .load  (main_load_s),
                .drop  (main_drop_s),
                .din   (in_data),
                .valid (main_valid_s),
                .dout  (main_data_s)
            );
        end
    endgenerate

    // Occupancy flop tracks the slot valids one-for-one.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_r <= 2'd0;
        end else begin
            occ_r <= valid_count(main_valid_nx_s, skid_valid_nx_s);
        end
    end

    assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Drives a SKID=1 and a SKID=0 instance of pipe_skid_stage from the same
// upstream/downstream stimulus. Each instance has its own reference FIFO: the
// stimulus side appends every accepted entry, the monitor compares every
// cycle's occupancy, in_ready, out_valid and out_data against the FIFO and
// pops on a downstream transfer. flush/rst empty the FIFO.
// -----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    typedef logic [15:0] word_t;
    localparam word_t RP = 16'hDEAD;

    logic  clk = 1'b0;
    logic  rst, flush, stall, in_valid, out_ready;
    word_t in_data;

    logic       ir1, ov1, ir0, ov0;
    word_t      od1, od0;
    logic [1:0] occ1, occ0;

    word_t exp_q [2][$];
    bit    clean [2];
    bit    mon_en = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(16), .SKID(1), .RESET_PAYLOAD(RP)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1)
    );

    pipe_skid_stage #(.WIDTH(16), .SKID(0), .RESET_PAYLOAD(RP)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(occ0)
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (skid=%0d) at %0t: got %0h, expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Reference behaviour: a FIFO of held entries, capacity 1+SKID.
    task automatic monitor_one(input int k, input logic ir, input logic ov, input word_t od, input logic [1:0] occ);
        int   held;
        logic m_ir;
        logic m_ov;
        held = exp_q[k].size();
        m_ov = (held > 0) && !stall;
        if (k == 1) m_ir = (held < 2);
        else        m_ir = (held == 0) || (out_ready && !stall);
        chk("occupancy", k, 32'(occ), 32'(held));
        chk("occ_bound", k, (occ <= 2'(1 + k)) ? 32'd1 : 32'd0, 32'd1);
        chk("in_ready", k, {31'b0, ir}, {31'b0, m_ir});
        chk("out_valid", k, {31'b0, ov}, {31'b0, m_ov});
        if (held > 0)
            chk("out_data", k, {16'b0, od}, {16'b0, exp_q[k][0]});
        else if (clean[k])
            chk("reset_data", k, {16'b0, od}, {16'b0, RP});
        if (m_ov && out_ready) void'(exp_q[k].pop_front());
        if (rst || flush) begin
            exp_q[k].delete();
            clean[k] = 1'b1;
        end
    endtask

    // Monitor: checks the state presented in the current cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            monitor_one(1, ir1, ov1, od1, occ1);
            monitor_one(0, ir0, ov0, od0, occ0);
        end
    end

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic iv, input word_t d, input logic ordy,
                        input logic st, input logic fl, input logic rs);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        rst       = rs;
        @(negedge clk);
        #1;
        if (iv && !fl && !rs) begin
            if (ir1) begin exp_q[1].push_back(d); clean[1] = 1'b0; end
            if (ir0) begin exp_q[0].push_back(d); clean[0] = 1'b0; end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0;
        clean[0] = 1'b1; clean[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) step(1'b1, word_t'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure: A, B, C offered while downstream is blocked.
        step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall with two entries held, then drain.
        step(1'b1, 16'h0041, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Flush with a coinciding push of D.
        step(1'b1, 16'h0051, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0052, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h000D, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Pop coinciding with flush.
        step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0056, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream, then resume.
        step(1'b1, 16'h0061, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0062, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0063, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, word_t'(16'h0070 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(3, 0) != 0, word_t'($urandom), $urandom_range(2, 0) != 0,
                 $urandom_range(7, 0) == 0, $urandom_range(31, 0) == 0, $urandom_range(96, 0) == 0);
        end

        // Drain, bounded.
        for (int i = 0; i < 20 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++)
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("final_occ", 1, 32'(occ1), 32'd0);
        chk("final_occ", 0, 32'(occ0), 32'd0);
        chk("final_valid", 1, {31'b0, ov1}, 32'd0);
        chk("final_valid", 0, {31'b0, ov0}, 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
